// File: rtl/cobro_bebida.sv
// Payment and selection front-end for the drink machine.
// Accumulates coin credit, validates selection, dispenses and returns change.
module cobro_bebida #(
    parameter int PRECIO_1      = 30,
    parameter int PRECIO_2      = 40,
    parameter int PRECIO_3      = 45,
    parameter int PRECIO_4      = 50,
    parameter int PRECIO_5      = 25,
    parameter int CREDITO_MAX   = 200,
    parameter int T_PREPARACION = 20,
    parameter int TIMEOUT       = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       moneda_valida,
    input  logic [1:0] valor_moneda,
    input  logic       seleccion_valida,
    input  logic [2:0] seleccion,
    input  logic       cancelar,
    output logic       preparar,
    output logic [2:0] tipo_bebida,
    output logic [7:0] credito,
    output logic [7:0] vuelto,
    output logic       vuelto_valido,
    output logic       moneda_rechazada,
    output logic       error_seleccion,
    output logic       ocupado
);

    typedef enum logic [1:0] {
        ESPERA,
        ACUMULANDO,
        DESPACHO,
        VUELTO
    } estado_t;

    localparam int CW = $clog2(TIMEOUT + T_PREPARACION + 1);

    estado_t       estado, estado_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    cred_n;
    logic [2:0]    tipo_n;
    logic          prep_n, rech_n, err_n;
    logic [8:0]    precio, valor, suma;
    logic          codigo_ok;

    // Price lookup for the requested drink code; unknown codes flagged invalid.
    always_comb begin
        precio    = 9'd0;
        codigo_ok = 1'b1;
        case (seleccion)
            3'b001:  precio = 9'(PRECIO_1);
            3'b010:  precio = 9'(PRECIO_2);
            3'b011:  precio = 9'(PRECIO_3);
            3'b100:  precio = 9'(PRECIO_4);
            3'b101:  precio = 9'(PRECIO_5);
            default: codigo_ok = 1'b0;
        endcase
    end

    // Coin value decode and 9-bit credit sum so the overflow check cannot wrap.
    always_comb begin
        case (valor_moneda)
            2'b00:   valor = 9'd5;
            2'b01:   valor = 9'd10;
            2'b10:   valor = 9'd25;
            default: valor = 9'd50;
        endcase
        suma = {1'b0, credito} + valor;
    end

    // Next-state and registered-output logic; cancel > selection > coin.
    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        cred_n   = credito;
        tipo_n   = tipo_bebida;
        prep_n   = 1'b0;
        rech_n   = 1'b0;
        err_n    = 1'b0;
        case (estado)
            ESPERA, ACUMULANDO: begin
                if (estado == ACUMULANDO)
                    cnt_n = cnt + 1'b1;
                if (cancelar) begin
                    rech_n = moneda_valida;
                    cnt_n  = '0;
                    if (estado == ACUMULANDO)
                        estado_n = VUELTO;
                end else if (seleccion_valida) begin
                    rech_n = moneda_valida;
                    cnt_n  = '0;
                    if (!codigo_ok || ({1'b0, credito} < precio)) begin
                        err_n = 1'b1;
                    end else begin
                        prep_n   = 1'b1;
                        tipo_n   = seleccion;
                        cred_n   = credito - precio[7:0];
                        estado_n = DESPACHO;
                    end
                end else if (moneda_valida) begin
                    cnt_n = '0;
                    if (suma <= 9'(CREDITO_MAX)) begin
                        cred_n   = suma[7:0];
                        estado_n = ACUMULANDO;
                    end else begin
                        rech_n = 1'b1;
                    end
                end else if (estado == ACUMULANDO &&
                             cnt == CW'(TIMEOUT - 1)) begin
                    cnt_n    = '0;
                    estado_n = VUELTO;
                end
            end
            DESPACHO: begin
                rech_n = moneda_valida;
                cnt_n  = cnt + 1'b1;
                if (cnt == CW'(T_PREPARACION - 1)) begin
                    cnt_n    = '0;
                    estado_n = (credito != 8'd0) ? VUELTO : ESPERA;
                end
            end
            default: begin
                rech_n   = moneda_valida;
                cnt_n    = '0;
                cred_n   = 8'd0;
                estado_n = ESPERA;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado           <= ESPERA;
            cnt              <= '0;
            credito          <= 8'd0;
            tipo_bebida      <= 3'd0;
            preparar         <= 1'b0;
            moneda_rechazada <= 1'b0;
            error_seleccion  <= 1'b0;
        end else begin
            estado           <= estado_n;
            cnt              <= cnt_n;
            credito          <= cred_n;
            tipo_bebida      <= tipo_n;
            preparar         <= prep_n;
            moneda_rechazada <= rech_n;
            error_seleccion  <= err_n;
        end
    end

    assign ocupado       = (estado == DESPACHO);
    assign vuelto_valido = (estado == VUELTO);
    assign vuelto        = vuelto_valido ? credito : 8'd0;

endmodule

// File: doc/cobro_bebida.md
Name: cobro_bebida

Overview:
- Payment and selection front-end for the drink machine; sits directly upstream of the preparation controller.
- Accumulates coin credit and validates the drink selection against a per-drink price.
- On success, issues a one-cycle `preparar` pulse with a held `tipo_bebida` code, then returns change after a fixed preparation hold-off.
- Handles cancel, inactivity timeout and coin rejection.

Parameters:
- PRECIO_1, 30: price of drink code 3'b001 (café), in credit units.
- PRECIO_2, 40: price of code 3'b010.
- PRECIO_3, 45: price of code 3'b011.
- PRECIO_4, 50: price of code 3'b100.
- PRECIO_5, 25: price of code 3'b101.
- CREDITO_MAX, 200: maximum accumulated credit; must be ≤ 255.
- T_PREPARACION, 20: cycles held in DESPACHO after the `preparar` pulse.
- TIMEOUT, 1000: idle cycles in ACUMULANDO before automatic refund.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low
- moneda_valida  in  1  one-cycle strobe: a coin is present
- valor_moneda  in  2  coin value: 00=5, 01=10, 10=25, 11=50
- seleccion_valida  in  1  one-cycle strobe: drink button pressed
- seleccion  in  3  requested drink code
- cancelar  in  1  one-cycle strobe: refund request
- preparar  out  1  one-cycle start pulse to the preparation controller
- tipo_bebida  out  3  drink code; held from the `preparar` cycle until the next dispense
- credito  out  8  current credit, registered
- vuelto  out  8  change amount; valid only while `vuelto_valido` = 1
- vuelto_valido  out  1  one-cycle change strobe
- moneda_rechazada  out  1  one-cycle pulse: coin not accepted
- error_seleccion  out  1  one-cycle pulse: invalid code or insufficient credit
- ocupado  out  1  high while in DESPACHO

Behaviour:
- Reset: when `rst` = 0 at a clk edge, all outputs go to 0 and state goes to ESPERA. Reset wins over all inputs and applies mid-operation; any credit is discarded without a `vuelto` pulse.
- States: ESPERA, ACUMULANDO, DESPACHO, VUELTO.
- Input priority within one cycle: cancelar > seleccion_valida > moneda_valida.
  - A coin strobe coinciding with a higher-priority event is not credited and raises `moneda_rechazada`.
- Coin acceptance (ESPERA or ACUMULANDO):
  - If credito + value ≤ CREDITO_MAX: credito updates on the next edge and state goes to ACUMULANDO.
  - Otherwise: coin rejected, credito unchanged.
- Selection:
  - Codes 000, 110 and 111 are invalid and raise `error_seleccion`.
  - A valid code with credito < price raises `error_seleccion`; credito and state are unchanged.
  - A valid code with credito ≥ price, in ESPERA or ACUMULANDO, does the following on that edge:
    - `preparar` = 1 for exactly one cycle;
    - `tipo_bebida` = code;
    - credito -= price;
    - state goes to DESPACHO.
  - Latency: strobe cycle N, `preparar` visible in cycle N+1.
- DESPACHO:
  - `ocupado` = 1.
  - Coins are rejected; selections and cancel are ignored with no error pulse.
  - After T_PREPARACION cycles: go to VUELTO if credito > 0, else to ESPERA.
- VUELTO (one cycle): `vuelto` = credito, `vuelto_valido` = 1; credito is cleared; then go to ESPERA.
- Cancel:
  - In ACUMULANDO: go to VUELTO, refunding the full credit.
  - In ESPERA: no effect.
- Timeout: an idle counter resets on any accepted strobe. Reaching TIMEOUT cycles in ACUMULANDO behaves exactly as cancel.
- Widths: credit arithmetic is 9-bit internally, so the overflow check cannot wrap; credito never exceeds CREDITO_MAX.
- Pulse outputs (`preparar`, `vuelto_valido`, `moneda_rechazada`, `error_seleccion`) never stay high for two consecutive cycles from the same event.

Test Plan:
- Reset then coins 25 and 10 (credito = 35), then select 001 → `preparar` pulses 1 cycle later with `tipo_bebida` = 001; after 20 cycles `vuelto` = 5 with `vuelto_valido` for 1 cycle; credito = 0.
- Credito = 40, select 100 (price 50) → `error_seleccion` pulse, credito stays 40, no `preparar`. Then select 111 → `error_seleccion` pulse.
- Insert four 50 coins (200), then a 5 coin → `moneda_rechazada` pulse, credito stays 200.
- Credito = 30 with cancel and a 10 coin in the same cycle → `vuelto` = 30, `moneda_rechazada` pulse, credito = 0.
- Credito = 10 with no activity for 1000 cycles → `vuelto` = 10 and state returns to ESPERA.
- Drive `rst` = 0 for one cycle during DESPACHO with credito = 15 → all outputs 0 on the next edge, no `vuelto` pulse. A coin inserted during DESPACHO (before the reset) raises `moneda_rechazada`.
